// File: rtl/comparator_serial.sv
// rtl/comparator_serial.sv - multi-cycle magnitude comparator, one CHUNK-bit slice per cycle MSB first
module comparator_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Greater_than,
  output logic             Less_than,
  output logic             Equal
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [WIDTH-1:0] a_cmp, b_cmp;
  logic [CHUNK-1:0] sa, sb;
  logic             capture, finish, res_gt, res_lt, res_eq;

  // Offset-binary: flipping the sign bit makes signed order match unsigned order.
  assign a_cmp = {a_q[WIDTH-1] ^ mode_q, a_q[WIDTH-2:0]};
  assign b_cmp = {b_q[WIDTH-1] ^ mode_q, b_q[WIDTH-2:0]};
  assign sa    = a_cmp[WIDTH-1-int'(idx)*CHUNK -: CHUNK];
  assign sb    = b_cmp[WIDTH-1-int'(idx)*CHUNK -: CHUNK];
  assign busy  = (state == CMP);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    finish    = 1'b0;
    res_gt    = 1'b0;
    res_lt    = 1'b0;
    res_eq    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (sa != sb) begin
          finish    = 1'b1;
          res_gt    = (sa > sb);
          res_lt    = (sa < sb);
          state_nxt = IDLE;
        end else if (idx == LAST) begin
          finish    = 1'b1;
          res_eq    = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= 1'b0;
      done         <= 1'b0;
      Greater_than <= 1'b0;
      Less_than    <= 1'b0;
      Equal        <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= finish;
      if (capture) begin
        a_q    <= A;
        b_q    <= B;
        mode_q <= signed_mode;
      end
      if (finish) begin
        Greater_than <= res_gt;
        Less_than    <= res_lt;
        Equal        <= res_eq;
      end
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// tb/tb_comparator_serial.sv - scoreboard bench for comparator_serial (WIDTH=16, CHUNK=4)
module tb_comparator_serial;

  logic        clk = 1'b0;
  logic        rst, start, signed_mode;
  logic [15:0] A, B;
  logic        busy, done, Greater_than, Less_than, Equal;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  comparator_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done),
    .Greater_than(Greater_than), .Less_than(Less_than), .Equal(Equal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected flags from a native compare; latency from the first differing chunk of A^B.
  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic sm);
    exp_t        e;
    logic [15:0] x;
    logic        gt, lt;
    bit          found;
    gt = sm ? ($signed(a) > $signed(b)) : (a > b);
    lt = sm ? ($signed(a) < $signed(b)) : (a < b);
    e.flags = {gt, lt, (a == b)};
    x = a ^ b;
    e.lat = 4;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && x[15-4*k -: 4] != 4'h0) begin
        e.lat = k + 1;
        found = 1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic sm);
    A = a; B = b; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        cyc = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst = 1'b0;
    tests_run++;
    if ({busy, done, Greater_than, Less_than, Equal} !== 5'b0) begin
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, Greater_than, Less_than, Equal});
      tests_failed++;
    end
  endtask

  task automatic run_case(input string name, input logic [15:0] a, input logic [15:0] b, input logic sm);
    exp_t e;
    int   cyc;
    push_exp(a, b, sm);
    do_start(a, b, sm);
    A = $urandom; B = $urandom; signed_mode = ~sm;
    wait_done(cyc);
    e = sb.pop_front();
    tests_run++;
    if ({Greater_than, Less_than, Equal} !== e.flags) begin
      $display("FAIL %s flags: got gt/lt/eq=%b expected %b", name, {Greater_than, Less_than, Equal}, e.flags);
      tests_failed++;
    end
    tests_run++;
    if (cyc !== e.lat) begin
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
      tests_failed++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
      tests_failed++;
    end
  endtask

  task automatic test_msb_boundary();
    run_case("unsigned_8000_7fff", 16'h8000, 16'h7FFF, 1'b0);
    run_case("signed_8000_7fff", 16'h8000, 16'h7FFF, 1'b1);
  endtask

  task automatic test_equal_full();
    run_case("equal_1234", 16'h1234, 16'h1234, 1'b0);
    run_case("lsb_1235_1234", 16'h1235, 16'h1234, 1'b0);
  endtask

  task automatic test_sign_extremes();
    run_case("signed_ffff_0001", 16'hFFFF, 16'h0001, 1'b1);
    run_case("unsigned_ffff_0001", 16'hFFFF, 16'h0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_t[3] = '{16'h1234, 16'h00F0, 16'hA000};
    logic [15:0] b_t[3] = '{16'h1234, 16'h00E0, 16'h5000};
    logic        s_t[3] = '{1'b0, 1'b0, 1'b1};
    exp_t        e;
    int          cyc;
    A = a_t[0]; B = b_t[0]; signed_mode = s_t[0]; start = 1'b1;
    push_exp(a_t[0], b_t[0], s_t[0]);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        A = a_t[i+1]; B = b_t[i+1]; signed_mode = s_t[i+1];
      end else begin
        A = $urandom; B = $urandom; start = 1'b0;
      end
      wait_done(cyc);
      e = sb.pop_front();
      tests_run++;
      if ({Greater_than, Less_than, Equal} !== e.flags || cyc !== e.lat) begin
        $display("FAIL b2b_%0d: got flags=%b lat=%0d expected flags=%b lat=%0d",
                 i, {Greater_than, Less_than, Equal}, cyc, e.flags, e.lat);
        tests_failed++;
      end
      if (i < 2) push_exp(a_t[i+1], b_t[i+1], s_t[i+1]);
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== (i < 2)) begin
        $display("FAIL b2b_after_%0d: got done=%b busy=%b expected done=0 busy=%b", i, done, busy, (i < 2));
        tests_failed++;
      end
    end
  endtask

  task automatic test_start_mid_cmp();
    exp_t e;
    int   cyc;
    push_exp(16'h4321, 16'h4321, 1'b0);
    do_start(16'h4321, 16'h4321, 1'b0);
    tick();
    A = 16'h0000; B = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    if (cyc > 0) cyc = cyc + 2;
    e = sb.pop_front();
    tests_run++;
    if ({Greater_than, Less_than, Equal} !== e.flags || cyc !== e.lat) begin
      $display("FAIL mid_start: got flags=%b lat=%0d expected flags=%b lat=%0d",
               {Greater_than, Less_than, Equal}, cyc, e.flags, e.lat);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL mid_start_ignored: got done=%b busy=%b expected 0 0", done, busy);
      tests_failed++;
    end
  endtask

  task automatic test_reset_abort();
    int saw_done = 0;
    do_start(16'h1234, 16'h1234, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({busy, done, Greater_than, Less_than, Equal} !== 5'b0) begin
      $display("FAIL abort_outputs: got %b expected 00000", {busy, done, Greater_than, Less_than, Equal});
      tests_failed++;
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done) saw_done++;
    end
    tests_run++;
    if (saw_done != 0 || {Greater_than, Less_than, Equal} !== 3'b0) begin
      $display("FAIL abort_no_done: got %0d done pulses flags=%b expected 0 and 000",
               saw_done, {Greater_than, Less_than, Equal});
      tests_failed++;
    end
    run_case("after_abort_0005_0009", 16'h0005, 16'h0009, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int n = 0; n < 20; n++) begin
      a = 16'($urandom);
      case ($urandom_range(2, 0))
        0:       b = a;
        1:       b = a ^ (16'h1 << $urandom_range(15, 0));
        default: b = 16'($urandom);
      endcase
      run_case($sformatf("random_%0d", n), a, b, 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_msb_boundary();
    test_equal_full();
    test_sign_extremes();
    test_back_to_back();
    test_start_mid_cmp();
    test_reset_abort();
    test_random();
    tests_run++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      tests_failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
